elastic_pipe: RTL and testbench

ELASTIC_PIPE -- requirements
Module: elastic_pipe

---
 rtl/elastic_pipe.sv | 89 ++++++++
 tb/tb_elastic_pipe.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/elastic_pipe.sv
// Elastic register pipeline with bubble collapsing: each stage loads whenever it is
// empty or the stage ahead of it can move, so gaps fill even while the output is stalled.

module elastic_stage #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             ready,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    // Data only moves with a valid item, so an invalid stage keeps its old contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (ready) begin
            valid <= src_valid;
            if (src_valid) data <= src_data;
        end
    end
endmodule

module elastic_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0][WIDTH-1:0] d;
    logic [DEPTH-1:0]            src_v;
    logic [DEPTH-1:0][WIDTH-1:0] src_d;
    logic [DEPTH:0]              r;

    assign r[DEPTH] = out_ready & ~flush;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_stage
            assign r[i] = ~v[i] | r[i+1];
            if (i == 0) begin : g_head
                assign src_v[i] = in_valid;
                assign src_d[i] = in_data;
            end else begin : g_body
                assign src_v[i] = v[i-1];
                assign src_d[i] = d[i-1];
            end
            elastic_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
                .clk       (clk),
                .reset     (reset),
                .flush     (flush),
                .ready     (r[i]),
                .src_valid (src_v[i]),
                .src_data  (src_d[i]),
                .valid     (v[i]),
                .data      (d[i])
            );
        end
    endgenerate

    assign in_ready  = r[0] & ~flush;
    assign out_valid = v[DEPTH-1] & ~flush;
    assign out_data  = d[DEPTH-1];

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) occupancy = occupancy + OW'(v[k]);
    end
endmodule

// File: tb/tb_elastic_pipe.sv
// Bench for elastic_pipe: directed scenarios plus random traffic, checked against a
// queue model where each item advances whenever any slot ahead is free or the exit is open.

module tb_elastic_pipe;
    localparam int W  = 8;
    localparam int D  = 3;
    localparam int OW = $clog2(D+1);

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  in_data, out_data;
    logic [OW-1:0] occupancy;

    always #5 clk = ~clk;

    elastic_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    int total = 0;
    int bad   = 0;
    bit started = 0;
    bit last_acc;

    typedef struct {
        logic [W-1:0] data;
        int           pos;
    } item_t;
    item_t q[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: items keep their slot index; the oldest is at the front.
    always @(posedge clk) begin
        if (reset || flush) begin
            q.delete();
        end else begin
            bit occ[D];
            bit acc;
            bit adv;
            for (int k = 0; k < D; k++) occ[k] = 1'b0;
            foreach (q[n]) occ[q[n].pos] = 1'b1;
            acc = in_valid && ((q.size() < D) || out_ready);
            if (q.size() > 0 && q[0].pos == D-1 && out_ready) void'(q.pop_front());
            foreach (q[n]) begin
                adv = out_ready;
                for (int k = q[n].pos + 1; k < D; k++) if (!occ[k]) adv = 1'b1;
                if (adv && q[n].pos < D-1) q[n].pos++;
            end
            if (acc) q.push_back('{data: in_data, pos: 0});
        end
    end

    // Monitor: compares handshake, occupancy and delivered data mid-cycle.
    always @(negedge clk) begin
        if (started) begin
            bit ev;
            ev = (q.size() > 0) && (q[0].pos == D-1) && !flush;
            chk("in_ready", 32'(in_ready), 32'(((q.size() < D) || out_ready) && !flush));
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("occupancy", 32'(occupancy), 32'(q.size()));
            if (ev && out_valid && out_ready) chk("out_data", 32'(out_data), 32'(q[0].data));
        end
    end

    task automatic cyc(input bit iv, input logic [W-1:0] dd, input bit ordy,
                       input bit fl, input bit rs);
        in_valid  = iv;
        in_data   = dd;
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        @(negedge clk);
        last_acc = in_valid & in_ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit           iv, hold, ordy, fl, rs;
        logic [W-1:0] dd;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk);
        #1 started = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Latency through an empty pipe
        cyc(1, 8'hA5, 1, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        chk("lat_not_yet", 32'(out_valid), 32'd0);
        cyc(0, 8'h00, 1, 0, 0);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data", 32'(out_data), 32'hA5);
        cyc(0, 8'h00, 1, 0, 0);
        chk("lat_drained", 32'(occupancy), 32'd0);
        repeat (2) cyc(0, 8'h00, 1, 0, 0);

        // Streaming
        for (int k = 1; k <= 16; k++) cyc(1, W'(k), 1, 0, 0);
        repeat (5) cyc(0, 8'h00, 1, 0, 0);

        // Backpressure with bubble collapse
        cyc(1, 8'h11, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);
        cyc(1, 8'h22, 0, 0, 0);
        cyc(1, 8'h33, 0, 0, 0);
        in_valid = 1'b1; in_data = 8'h44;
        chk("bp_full_occ", 32'(occupancy), 32'd3);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        cyc(1, 8'h44, 0, 0, 0);
        cyc(1, 8'h44, 0, 0, 0);
        cyc(1, 8'h44, 1, 0, 0);
        chk("bp_swap_acc", 32'(last_acc), 32'd1);
        chk("bp_swap_occ", 32'(occupancy), 32'd3);
        repeat (4) cyc(0, 8'h00, 1, 0, 0);

        // Flush
        cyc(1, 8'h55, 0, 0, 0);
        cyc(1, 8'h66, 0, 0, 0);
        chk("fl_occ_before", 32'(occupancy), 32'd2);
        cyc(1, 8'h77, 0, 1, 0);
        chk("fl_no_accept", 32'(last_acc), 32'd0);
        chk("fl_occ_after", 32'(occupancy), 32'd0);
        repeat (4) cyc(0, 8'h00, 1, 0, 0);

        // Reset mid-operation
        cyc(1, 8'h81, 0, 0, 0);
        cyc(1, 8'h82, 0, 0, 0);
        cyc(1, 8'h83, 0, 0, 0);
        chk("mr_occ_full", 32'(occupancy), 32'd3);
        cyc(0, 8'h00, 0, 0, 1);
        chk("mr_occ", 32'(occupancy), 32'd0);
        chk("mr_data", 32'(out_data), 32'h00);
        repeat (5) cyc(0, 8'h00, 1, 0, 0);

        // Random traffic with occasional flush/reset and shifting backpressure
        hold = 1'b0;
        dd   = '0;
        for (int n = 0; n < 3000; n++) begin
            fl   = ($urandom_range(0, 59) == 0);
            rs   = ($urandom_range(0, 249) == 0);
            ordy = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            if (!hold) begin
                iv = ($urandom_range(0, 2) != 0);
                dd = W'($urandom);
            end
            cyc(iv, dd, ordy, fl, rs);
            hold = iv && !last_acc && !fl && !rs;
        end
        repeat (6) cyc(0, 8'h00, 1, 0, 0);
        chk("end_drained", 32'(occupancy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
